sram_port_master: RTL and testbench

- Initiator side of the single-port SRAM macro interface (csb0/web0/addr0/din0/dout0, active-low controls).
- Accepts read or write burst requests on a valid/ready command channel, streams write data in, and streams read data out.
- Sequences the macro pins cycle by cycle, and absorbs read latency and response backpressure with a small response buffer.
- Sits between the core's load/store logic and the SRAM wrapper; the wrapper still runs the macro on the inverted clock.

---
 rtl/sram_port_pkg.sv | 20 ++
 rtl/sram_rsp_fifo.sv | 47 ++++
 rtl/sram_port_master.sv | 153 +++++++++++++++
 tb/tb_sram_port_master.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_pkg.sv
// Shared widths, controller state encoding and response beat layout for the SRAM port master.
package sram_port_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rsp_beat_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read-response beats, with an occupancy count for credit checks.
module sram_rsp_fifo
  import sram_port_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  rsp_beat_t        push_beat,
  input  logic             pop,
  output rsp_beat_t        head,
  output logic [OCC_W-1:0] occupancy
);

  rsp_beat_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_beat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_port_master.sv
// Burst initiator for the single-port SRAM macro: sequences csb0/web0/addr0/din0 and buffers read data.
module sram_port_master
  import sram_port_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0
);

  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CRD_W = OCC_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic              csb_d, web_d, wr_done_d;
  logic [ADDR_W-1:0] addr0_d;
  logic [DATA_W-1:0] din0_d;
  logic [OCC_W-1:0]  occ, occ_next;
  logic [CRD_W-1:0]  credit_used;
  logic              rsp_pop, cmd_fire, wd_fire;
  rsp_beat_t         push_beat, head;

  assign rsp_valid = (occ != '0);
  assign rsp_data  = head.data;
  assign rsp_last  = rsp_valid && head.last;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wd_fire   = wd_valid && wd_ready;

  // A beat leaving the buffer this cycle frees its slot, so back-to-back reads need no bubble.
  assign credit_used = CRD_W'(occ) + CRD_W'(rd_pend_q) - CRD_W'(rsp_pop);
  assign occ_next    = occ + OCC_W'(rd_pend_q) - OCC_W'(rsp_pop);

  assign push_beat.data = sram_dout0;
  assign push_beat.last = rd_last_q;

  sram_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pend_q),
    .push_beat (push_beat),
    .pop       (rsp_pop),
    .head      (head),
    .occupancy (occ)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_pend_d = 1'b0;
    rd_last_d = 1'b0;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    addr0_d   = sram_addr0;
    din0_d    = sram_din0;
    wr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WR : RD;
        end
      end
      RD: begin
        if (credit_used < CRD_W'(RSP_DEPTH)) begin
          csb_d     = 1'b0;
          addr0_d   = addr_q;
          rd_pend_d = 1'b1;
          rd_last_d = (cnt_q == '0);
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      WR: begin
        if (wd_fire) begin
          csb_d   = 1'b0;
          web_d   = 1'b0;
          addr0_d = addr_q;
          din0_d  = wd_data;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d   = IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!rd_pend_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_last_q  <= 1'b0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      cmd_ready  <= 1'b0;
      wd_ready   <= 1'b0;
      wr_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_last_q  <= rd_last_d;
      sram_csb0  <= csb_d;
      sram_web0  <= web_d;
      sram_addr0 <= addr0_d;
      sram_din0  <= din0_d;
      cmd_ready  <= (state_d == IDLE);
      wd_ready   <= (state_d == WR);
      wr_done    <= wr_done_d;
      busy       <= (state_d != IDLE) || (occ_next != '0);
    end
  end

endmodule

// File: tb/tb_sram_port_master.sv
// Scoreboard bench for sram_port_master: a macro model on the inverted clock plus a reference memory.
`timescale 1ns/1ps
module tb_sram_port_master;
  import sram_port_pkg::*;

  localparam int unsigned WORDS = 2 ** ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wd_valid, wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic              rsp_valid, rsp_ready, rsp_last;
  logic [DATA_W-1:0] rsp_data;
  logic              wr_done, busy;
  logic              sram_csb0, sram_web0;
  logic [ADDR_W-1:0] sram_addr0;
  logic [DATA_W-1:0] sram_din0;
  logic [DATA_W-1:0] sram_dout0 = '0;

  sram_port_master #(.RSP_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done), .busy(busy),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pin_t;

  pin_t              exp_pin [$];
  rsp_beat_t         exp_rsp [$];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W-1:0] wbuf [16];

  int n_checks = 0, n_fails = 0;
  int n_rd_issue = 0, n_wr_issue = 0, n_rsp = 0, n_wr_done = 0;
  int cs_run_max = 0, rv_run_max = 0;
  int rr_mode = 0;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'(32'h5A000000 ^ (i * 32'h00010203));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Macro model: samples pins on the falling edge, read data visible by the next rising edge.
  initial begin
    logic [DATA_W-1:0] mem [WORDS];
    for (int i = 0; i < int'(WORDS); i++) mem[i] = init_val(i);
    forever begin
      @(negedge clock);
      if (!sram_csb0) begin
        if (!sram_web0) mem[sram_addr0] = sram_din0;
        else            sram_dout0      = mem[sram_addr0];
      end
    end
  end

  // Response consumer: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboards whenever the DUT drives the macro or presents a response.
  initial begin
    bit   prev_wd_acc = 1'b0;
    int   cs_run = 0, rv_run = 0;
    pin_t p;
    rsp_beat_t r;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_wd_acc = 1'b0;
        cs_run      = 0;
        rv_run      = 0;
      end else begin
        check("wr_pin_after_beat", 64'(!sram_csb0 && !sram_web0), 64'(prev_wd_acc));
        prev_wd_acc = wd_valid && wd_ready;
        if (wr_done) n_wr_done++;
        if (!sram_csb0) begin
          if (sram_web0) n_rd_issue++; else n_wr_issue++;
          cs_run++;
          if (cs_run > cs_run_max) cs_run_max = cs_run;
          if (exp_pin.size() == 0) begin
            check("pin_unexpected_issue", 64'(1), 64'(0));
          end else begin
            p = exp_pin.pop_front();
            check("pin_we", 64'(!sram_web0), 64'(p.we));
            check("pin_addr", 64'(sram_addr0), 64'(p.addr));
            if (p.we) check("pin_din", 64'(sram_din0), 64'(p.data));
          end
        end else begin
          cs_run = 0;
        end
        if (rsp_valid) begin
          rv_run++;
          if (rv_run > rv_run_max) rv_run_max = rv_run;
        end else begin
          rv_run = 0;
        end
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          if (exp_rsp.size() == 0) begin
            check("rsp_unexpected_beat", 64'(1), 64'(0));
          end else begin
            r = exp_rsp.pop_front();
            check("rsp_data", 64'(rsp_data), 64'(r.data));
            check("rsp_last", 64'(rsp_last), 64'(r.last));
          end
        end
      end
    end
  end

  // Issue one command; on acceptance record expectations, then stream write beats.
  // gap_mode: 0 = no gaps, 1 = one idle cycle between beats, 2 = random gaps.
  task automatic run_cmd(input bit wr, input logic [ADDR_W-1:0] a, input int len, input int gap_mode);
    bit ok = 1'b0;
    logic [ADDR_W-1:0] ai;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = LEN_W'(len);
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clock);
      ok = cmd_ready;
      @(posedge clock);
      #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 64'(ok), 64'(1));
    if (!ok) return;
    for (int i = 0; i <= len; i++) begin
      ai = a + ADDR_W'(i);
      if (wr) begin
        ref_mem[ai] = wbuf[i];
        exp_pin.push_back('{we: 1'b1, addr: ai, data: wbuf[i]});
      end else begin
        exp_pin.push_back('{we: 1'b0, addr: ai, data: '0});
        exp_rsp.push_back('{data: ref_mem[ai], last: (i == len)});
      end
    end
    if (!wr) return;
    for (int i = 0; i <= len; i++) begin
      if (gap_mode == 1 && i > 0) begin
        wd_valid = 1'b0;
        @(posedge clock);
        #1;
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          wd_valid = 1'b0;
          @(posedge clock);
          #1;
        end
      end
      wd_valid = 1'b1;
      wd_data  = wbuf[i];
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clock);
        ok = wd_ready;
        @(posedge clock);
        #1;
      end
      check("wd_accepted", 64'(ok), 64'(1));
    end
    wd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clock);
      done = !busy && (exp_rsp.size() == 0) && (exp_pin.size() == 0);
    end
    check("idle_reached", 64'(done), 64'(1));
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base_a, base_b, n_wr_bursts;
    bit wr;
    bit hit;
    int len;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_val(i);
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_csb0", 64'(sram_csb0), 64'(1));
    check("reset_web0", 64'(sram_web0), 64'(1));
    check("reset_addr0", 64'(sram_addr0), 64'(0));
    check("reset_din0", 64'(sram_din0), 64'(0));
    check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    check("reset_wd_ready", 64'(wd_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_last", 64'(rsp_last), 64'(0));
    check("reset_wr_done", 64'(wr_done), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle_cmd_ready", 64'(cmd_ready), 64'(1));

    // Single write then read back.
    base_a = n_wr_done; base_b = n_wr_issue;
    wbuf[0] = 32'hDEADBEEF;
    run_cmd(1'b1, 7'h05, 0, 0);
    wait_idle();
    check("single_wr_done_count", 64'(n_wr_done - base_a), 64'(1));
    check("single_wr_issue_count", 64'(n_wr_issue - base_b), 64'(1));
    base_a = n_rsp;
    run_cmd(1'b0, 7'h05, 0, 0);
    wait_idle();
    check("single_rd_beats", 64'(n_rsp - base_a), 64'(1));

    // Burst wrapping past the top address.
    for (int i = 0; i < 4; i++) wbuf[i] = DATA_W'(i + 1);
    base_a = n_wr_done;
    run_cmd(1'b1, 7'h7E, 3, 0);
    wait_idle();
    check("wrap_wr_done_count", 64'(n_wr_done - base_a), 64'(1));
    base_a = n_rsp;
    run_cmd(1'b0, 7'h7E, 3, 0);
    wait_idle();
    check("wrap_rd_beats", 64'(n_rsp - base_a), 64'(4));

    // Backpressure: only the buffer's worth of reads may issue.
    rr_mode = 2;
    @(posedge clock);
    #1;
    base_a = n_rd_issue; base_b = n_rsp;
    run_cmd(1'b0, 7'h20, 7, 0);
    repeat (10) @(posedge clock);
    #1;
    check("bp_issue_count", 64'(n_rd_issue - base_a), 64'(2));
    check("bp_csb0_held", 64'(sram_csb0), 64'(1));
    check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    check("bp_busy", 64'(busy), 64'(1));
    rr_mode = 0;
    wait_idle();
    check("bp_total_beats", 64'(n_rsp - base_b), 64'(8));

    // Throughput with the consumer always ready.
    cs_run_max = 0; rv_run_max = 0;
    run_cmd(1'b0, 7'h40, 15, 0);
    wait_idle();
    check("tput_csb0_run", 64'(cs_run_max), 64'(16));
    check("tput_rsp_valid_run", 64'(rv_run_max), 64'(16));

    // Gapped write data.
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    cs_run_max = 0; base_a = n_wr_done; base_b = n_wr_issue;
    run_cmd(1'b1, 7'h30, 2, 1);
    wait_idle();
    check("stall_wr_issue_count", 64'(n_wr_issue - base_b), 64'(3));
    check("stall_wr_done_count", 64'(n_wr_done - base_a), 64'(1));
    check("stall_max_csb0_run", 64'(cs_run_max), 64'(1));

    // Reset in the middle of a read burst.
    base_a = n_rd_issue;
    run_cmd(1'b0, 7'h10, 7, 0);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clock);
      hit = (n_rd_issue - base_a) >= 3;
    end
    check("midrst_reached_beat3", 64'(hit), 64'(1));
    #1;
    reset = 1'b1;
    #1;
    check("midrst_csb0", 64'(sram_csb0), 64'(1));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    exp_pin.delete();
    exp_rsp.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    base_a = n_rsp;
    run_cmd(1'b0, 7'h05, 0, 0);
    wait_idle();
    check("midrst_reread_beats", 64'(n_rsp - base_a), 64'(1));

    // Random back-to-back traffic with a jittery consumer.
    rr_mode = 1;
    n_wr_bursts = 0;
    base_a = n_wr_done;
    for (int k = 0; k < 40; k++) begin
      wr  = bit'($urandom_range(0, 1));
      len = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      if (wr) n_wr_bursts++;
      run_cmd(wr, ADDR_W'($urandom), len, 2);
    end
    rr_mode = 0;
    wait_idle();
    check("rand_wr_done_count", 64'(n_wr_done - base_a), 64'(n_wr_bursts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

endmodule
